lin2log_converter: RTL and testbench
====================================

// Module: lin2log_converter
// PURPOSE
//  Inverse of the log->linear attenuation lookup: converts a signed linear magnitude into
//  the sign + 7.6 fixed-point log-attenuation code consumed by the log->linear table.
//  Multi-cycle: a binary search over the shared 128-entry LOG2LIN table (package vm2413),
//  then a 6-bit restoring division for the fraction. Serves the envelope/feedback paths.
//  Valid/ready on both sides; one conversion in flight.
// PARAMETERS
//  none. Table is vm2413::LOG2LIN[0:127], 9-bit, monotone non-increasing:
//  [0]=511, [1]=489, [12]=304, [13]=291, [16]=256, [17]=245, [126]=2, [127]=0.
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  reset      in   1   asynchronous, active-low (0 = reset), clears all state immediately
//  in_valid   in   1   request valid
//  in_ready   out  1   block idle, request accepted on in_valid&&in_ready edge
//  in_sign    in   1   sign of linear sample (1 = negative)
//  in_value   in   9   unsigned linear magnitude v, 0..511
//  out_valid  out  1   result valid, held until out_ready
//  out_ready  in   1   consumer accepts result
//  out_addr   out  14  [13]=sign, [12:6]=integer index I, [5:0]=fraction F
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, out_addr=0; all working registers 0.
//  FSM: IDLE -> SEARCH (7 cycles) -> FETCH (1) -> DIVIDE (6) -> DONE -> IDLE.
//  IDLE: in_ready=1. On accept edge: latch in_sign and v, clear idx, bit counter=6 -> SEARCH.
//  SEARCH: one step per cycle, bit b = 6..0: cand = idx | (1<<b);
//    if cand <= 126 and LOG2LIN[cand] >= v then idx <= cand.
//    Result: idx = largest i in 0..126 with LOG2LIN[i] >= v ([0]=511 always qualifies).
//  FETCH: hi = LOG2LIN[idx], lo = LOG2LIN[idx+1]; num = hi - v, den = hi - lo (9-bit unsigned).
//  DIVIDE: 6-step restoring division, MSB first, computes F = floor(64*num/den).
//    Since lo < v <= hi for v >= 1: den >= 1 and F <= 63, so no clamp or divide-by-zero
//    path is required.
//  DONE: out_valid=1; out_addr = {sign, idx[6:0], F}.
//    Special case v==0: out_addr = {sign, 13'h1FFF} (maximum attenuation). Sign is never
//    altered, including for zero.
//  Latency fixed for every v: out_valid rises after the 14th rising edge following the
//    accept edge. The v==0 case is substituted at DONE and does not shorten latency.
//  Handshake: out_addr and out_valid stay stable while out_valid && !out_ready.
//    The out_valid&&out_ready edge returns to IDLE; in_ready=1 the following cycle.
//    There is no same-cycle turnaround: in_ready=0 in every state except IDLE.
//    in_sign and in_value are ignored outside IDLE.
//  Reset asserted mid-conversion: abort immediately to reset values; the partial result
//    is discarded and no out_valid pulse follows release.
//  Widths: all table and difference arithmetic is 9-bit unsigned; the division
//    remainder is 10 bits to hold the 2*rem shift.
// TESTING
//  T1 v=256, sign=0 -> out_addr=14'h0400 (I=16, F=0); out_valid exactly 14 edges after accept.
//  T2 v=300, sign=1 -> hi=304, lo=291, F=floor(256/13)=19 -> out_addr=14'h2313.
//  T3 boundaries: v=511 -> 14'h0000; v=1 -> 14'h1FA0 (I=126, F=32);
//     v=0 with sign=1 -> 14'h3FFF.
//  T4 plateau v=20 (entries 74 and 75 are both 20) -> I=75, F=0 -> 14'h12C0.
//  T5 hold out_ready=0 for 5 cycles -> out_addr stable and in_ready=0 throughout;
//     releasing out_ready -> in_ready=1 on the next cycle.
//  T6 reset low at SEARCH cycle 3 -> in_ready=1, out_valid=0 immediately; no result follows.
//  Sweep: for v=1..511, out_addr driven into the log->linear table returns
//     T[I] - floor(F*(T[I]-T[I+1])/64) equal to v or v+1.

Source files
------------

// File: rtl/lin2log_converter.sv
// ---------------------------------------------------------------------------
// lin2log_converter
//
// Purpose:
//   Converts a signed linear magnitude into the sign + 7.6 fixed-point
//   log-attenuation code consumed by the log->linear lookup. It is the
//   inverse of that lookup.
//   The integer part comes from a 7-step binary search over the shared
//   128-entry LOG2LIN table. The fractional part comes from a 6-step
//   restoring division that interpolates between the two table entries
//   that bracket the input.
//   Only one conversion is in flight at a time.
//
// Ports:
//   clk        in   1   single clock, all state on the rising edge
//   reset      in   1   asynchronous, active-low (0 = reset)
//   in_valid   in   1   request valid
//   in_ready   out  1   high only while idle; request taken on valid&&ready
//   in_sign    in   1   sign of the linear sample (1 = negative)
//   in_value   in   9   unsigned linear magnitude 0..511
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts the result
//   out_addr   out  14  {sign, integer index[6:0], fraction[5:0]}
// ---------------------------------------------------------------------------

package vm2413;

  // Attenuation table shared with the log->linear path. Entries follow
  // 511 * 10^(-0.375 dB * i / 20), truncated, and the last entry is forced
  // to 0. The table is monotone non-increasing.
  localparam logic [8:0] LOG2LIN [0:127] = '{
    9'd511, 9'd489, 9'd468, 9'd448, 9'd429, 9'd411, 9'd394, 9'd377,
    9'd361, 9'd346, 9'd331, 9'd317, 9'd304, 9'd291, 9'd279, 9'd267,
    9'd256, 9'd245, 9'd234, 9'd224, 9'd215, 9'd206, 9'd197, 9'd189,
    9'd181, 9'd173, 9'd166, 9'd159, 9'd152, 9'd146, 9'd139, 9'd134,
    9'd128, 9'd122, 9'd117, 9'd112, 9'd107, 9'd103, 9'd99,  9'd94,
    9'd90,  9'd87,  9'd83,  9'd79,  9'd76,  9'd73,  9'd70,  9'd67,
    9'd64,  9'd61,  9'd59,  9'd56,  9'd54,  9'd51,  9'd49,  9'd47,
    9'd45,  9'd43,  9'd41,  9'd40,  9'd38,  9'd36,  9'd35,  9'd33,
    9'd32,  9'd30,  9'd29,  9'd28,  9'd27,  9'd25,  9'd24,  9'd23,
    9'd22,  9'd21,  9'd20,  9'd20,  9'd19,  9'd18,  9'd17,  9'd16,
    9'd16,  9'd15,  9'd14,  9'd14,  9'd13,  9'd13,  9'd12,  9'd11,
    9'd11,  9'd10,  9'd10,  9'd10,  9'd9,   9'd9,   9'd8,   9'd8,
    9'd8,   9'd7,   9'd7,   9'd7,   9'd6,   9'd6,   9'd6,   9'd5,
    9'd5,   9'd5,   9'd5,   9'd5,   9'd4,   9'd4,   9'd4,   9'd4,
    9'd4,   9'd3,   9'd3,   9'd3,   9'd3,   9'd3,   9'd3,   9'd3,
    9'd2,   9'd2,   9'd2,   9'd2,   9'd2,   9'd2,   9'd2,   9'd0
  };

endpackage

module lin2log_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] out_addr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    FETCH  = 3'd2,
    DIVIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_sign;
  logic [8:0]  r_v;
  logic [6:0]  r_idx;
  logic [2:0]  r_bit;
  logic [8:0]  r_den;
  logic [9:0]  r_rem;
  logic [5:0]  r_quo;
  logic [13:0] r_outAddr;

  logic [6:0]  w_cand;
  logic        w_candOk;
  logic [8:0]  w_hi;
  logic [8:0]  w_lo;
  logic [8:0]  w_num;
  logic [8:0]  w_den;
  logic [9:0]  w_remShift;
  logic        w_subOk;
  logic [9:0]  w_remNext;
  logic [5:0]  w_quoNext;

  // Binary search step. Bit r_bit is tentatively set in the index. It is
  // kept when the candidate stays inside 0..126 and its table entry still
  // covers v. Index 127 is excluded so that FETCH always has a valid upper
  // neighbour at idx+1.
  always_comb begin
    w_cand   = r_idx | (7'd1 << r_bit);
    w_candOk = (w_cand <= 7'd126) && (vm2413::LOG2LIN[w_cand] >= r_v);
  end

  // Interpolation operands. These are 9-bit unsigned values.
  // For v >= 1 the bracket satisfies lo < v <= hi, so num < den and den >= 1.
  always_comb begin
    w_hi  = vm2413::LOG2LIN[r_idx];
    w_lo  = vm2413::LOG2LIN[r_idx + 7'd1];
    w_num = w_hi - r_v;
    w_den = w_hi - w_lo;
  end

  // One restoring-division step, MSB first. The remainder is 10 bits wide
  // so that the doubled remainder never overflows before it is compared
  // against the divisor.
  always_comb begin
    w_remShift = r_rem << 1;
    w_subOk    = (w_remShift >= {1'b0, r_den});
    w_remNext  = w_subOk ? (w_remShift - {1'b0, r_den}) : w_remShift;
    w_quoNext  = {r_quo[4:0], w_subOk};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake outputs. The block is ready only while
  // IDLE, so a result cannot be handed off and a new request accepted in
  // the same cycle.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = SEARCH;
        end
      end
      SEARCH: begin
        if (r_bit == 3'd0) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        w_nextState = DIVIDE;
      end
      DIVIDE: begin
        if (r_bit == 3'd0) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. r_bit is reused: it counts 6..0 during SEARCH and
  // 5..0 during DIVIDE.
  // The output code is captured on the last divide step, so it holds
  // steady for as long as the consumer stalls.
  // For v == 0 the full search and division still run, which keeps the
  // latency fixed. Only the captured code is replaced with maximum
  // attenuation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign    <= 1'b0;
      r_v       <= 9'd0;
      r_idx     <= 7'd0;
      r_bit     <= 3'd0;
      r_den     <= 9'd0;
      r_rem     <= 10'd0;
      r_quo     <= 6'd0;
      r_outAddr <= 14'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            r_v    <= in_value;
            r_idx  <= 7'd0;
            r_bit  <= 3'd6;
          end
        end
        SEARCH: begin
          if (w_candOk) begin
            r_idx <= w_cand;
          end
          if (r_bit != 3'd0) begin
            r_bit <= r_bit - 3'd1;
          end
        end
        FETCH: begin
          r_rem <= {1'b0, w_num};
          r_den <= w_den;
          r_quo <= 6'd0;
          r_bit <= 3'd5;
        end
        DIVIDE: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          if (r_bit == 3'd0) begin
            if (r_v == 9'd0) begin
              r_outAddr <= {r_sign, 13'h1FFF};
            end else begin
              r_outAddr <= {r_sign, r_idx, w_quoNext};
            end
          end else begin
            r_bit <= r_bit - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_addr = r_outAddr;

endmodule

// File: tb/tb_lin2log_converter.sv
// ---------------------------------------------------------------------------
// tb_lin2log_converter
//
// Purpose:
//   Scoreboard bench for lin2log_converter. The stimulus side pushes the
//   expected code for each request it issues. An independent monitor pops
//   and compares whenever a result is handed off.
//   The directed vectors carry hand-computed codes. The full 1..511 sweep
//   uses a small reference model and also checks that each result
//   round-trips through the log->linear interpolation back to v or v+1.
// ---------------------------------------------------------------------------

module tb_lin2log_converter;

  // Reference copy of the attenuation table.
  int T [0:127] = '{
    511, 489, 468, 448, 429, 411, 394, 377, 361, 346, 331, 317, 304, 291, 279, 267,
    256, 245, 234, 224, 215, 206, 197, 189, 181, 173, 166, 159, 152, 146, 139, 134,
    128, 122, 117, 112, 107, 103,  99,  94,  90,  87,  83,  79,  76,  73,  70,  67,
     64,  61,  59,  56,  54,  51,  49,  47,  45,  43,  41,  40,  38,  36,  35,  33,
     32,  30,  29,  28,  27,  25,  24,  23,  22,  21,  20,  20,  19,  18,  17,  16,
     16,  15,  14,  14,  13,  13,  12,  11,  11,  10,  10,  10,   9,   9,   8,   8,
      8,   7,   7,   7,   6,   6,   6,   5,   5,   5,   5,   5,   4,   4,   4,   4,
      4,   3,   3,   3,   3,   3,   3,   3,   2,   2,   2,   2,   2,   2,   2,   0
  };

  typedef struct {
    logic [13:0] addr;
    int          v;
    bit          roundTrip;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_value;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_addr;

  exp_t expQ[$];
  int   checks;
  int   errors;

  lin2log_converter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its required value and counts it.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference conversion: pick the largest bracketing index, then compute
  // the floored interpolation fraction with plain integer division.
  function automatic logic [13:0] modelAddr(input logic s, input int v);
    int idx;
    int hi;
    int lo;
    int f;
    if (v == 0) begin
      return {s, 13'h1FFF};
    end
    idx = 0;
    for (int i = 0; i <= 126; i++) begin
      if (T[i] >= v) begin
        idx = i;
      end
    end
    hi = T[idx];
    lo = T[idx + 1];
    f  = (64 * (hi - v)) / (hi - lo);
    return {s, idx[6:0], f[5:0]};
  endfunction

  // Issues one request once the DUT is idle, and optionally records the
  // expected result. Outside the accept cycle the data inputs are
  // scrambled; the DUT must ignore them.
  task automatic applyStimulus(input logic s, input int v, input logic [13:0] e,
                               input bit rt, input bit push);
    int n;
    exp_t item;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready wait", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_value = v[8:0];
    if (push) begin
      item.addr      = e;
      item.v         = v;
      item.roundTrip = rt;
      expQ.push_back(item);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = ~s;
    in_value = ~v[8:0];
  endtask

  // Waits, with a cycle bound, until every expected result has been seen.
  task automatic waitDrain();
    for (int n = 0; n < 200 && expQ.size() != 0; n++) begin
      @(posedge clk);
    end
    checkOutput("drain", expQ.size(), 0);
    expQ.delete();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each handoff, pops the oldest expectation and compares
  // against it. Sweep entries also get the round-trip property check.
  always @(negedge clk) begin
    exp_t got;
    int   ii;
    int   ff;
    int   hi;
    int   lo;
    int   back;
    if (reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: got 0x%0h, required no output", out_addr);
      end else begin
        got = expQ.pop_front();
        checkOutput($sformatf("addr v=%0d", got.v), int'(out_addr), int'(got.addr));
        if (got.roundTrip) begin
          ii   = int'(out_addr[12:6]);
          ff   = int'(out_addr[5:0]);
          hi   = T[ii];
          lo   = (ii < 127) ? T[ii + 1] : 0;
          back = hi - (ff * (hi - lo)) / 64;
          checkOutput($sformatf("roundtrip v=%0d", got.v),
                      ((back == got.v) || (back == got.v + 1)) ? 1 : 0, 1);
        end
      end
    end
  end

  // Safety net against a hung DUT.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int seen;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_value  = 9'd0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_addr", out_addr, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // T1: exact index hit, and latency of 14 edges after accept.
    $display("[TB] T1 v=256 latency");
    applyStimulus(1'b0, 256, 14'h0400, 1'b0, 1'b1);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    checkOutput("T1 latency", n, 14);
    waitDrain();

    // T2 to T4: interpolation, boundaries, zero with sign, plateau.
    $display("[TB] T2-T4 directed vectors");
    applyStimulus(1'b1, 300, 14'h2313, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 511, 14'h0000, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b0,   1, 14'h1FA0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b1,   0, 14'h3FFF, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b0,   0, 14'h1FFF, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b0,  20, 14'h12C0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 245, 14'h2440, 1'b0, 1'b1);
    waitDrain();

    // T5: consumer stall keeps the result stable and the input closed.
    $display("[TB] T5 output stall");
    out_ready = 1'b0;
    applyStimulus(1'b0, 300, 14'h0313, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("T5 hold addr c%0d", c), out_addr, 14'h0313);
      checkOutput($sformatf("T5 hold valid c%0d", c), out_valid, 1);
      checkOutput($sformatf("T5 hold in_ready c%0d", c), in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("T5 in_ready after handoff", in_ready, 1);
    checkOutput("T5 out_valid after handoff", out_valid, 0);
    waitDrain();

    // T6: reset in the third SEARCH cycle aborts the conversion.
    $display("[TB] T6 reset mid-search");
    applyStimulus(1'b0, 100, 14'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("T6 in_ready in reset", in_ready, 1);
    checkOutput("T6 out_valid in reset", out_valid, 0);
    checkOutput("T6 out_addr in reset", out_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("T6 no result after abort", seen, 0);
    @(posedge clk);
    #1;

    // Sweep: model-based expected codes plus the round-trip property.
    $display("[TB] sweep v=1..511");
    for (int v = 1; v <= 511; v++) begin
      applyStimulus(v[0], v, modelAddr(v[0], v), 1'b1, 1'b1);
    end
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
